io_input_cond: RTL and testbench

//  Input conditioner for the board push-buttons (A, B, calc) and 16 slide switches.

---
 rtl/io_input_cond.sv | 91 +++++++++
 tb/tb_io_input_cond.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/io_input_cond.sv
// rtl/io_input_cond.sv - synchronise and debounce push-buttons and slide switches
// Define IO_SWITCH_DEBOUNCE_EN to debounce the switch bits as well as the buttons.
module io_input_cond #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int SW_WIDTH        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_a_raw,
    input  logic                btn_b_raw,
    input  logic                btn_calc_raw,
    input  logic [SW_WIDTH-1:0] switch_raw,
    output logic                A,
    output logic                B,
    output logic                calc,
    output logic [SW_WIDTH-1:0] switch,
    output logic                a_press,
    output logic                b_press,
    output logic                calc_press
);
    localparam int N  = 3 + SW_WIDTH;
`ifdef IO_SWITCH_DEBOUNCE_EN
    localparam int NDB = N;
`else
    localparam int NDB = 3;
`endif
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
    logic [NDB-1:0][CW-1:0]        cnt_q, cnt_d;
    logic [NDB-1:0]                stable_q, stable_d;
    logic [2:0]                    press_q, press_d;
    logic [N-1:0]                  raw;
    logic [N-1:0]                  s;

    assign raw = {switch_raw, btn_calc_raw, btn_b_raw, btn_a_raw};

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = raw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        s = sync_q[SYNC_STAGES-1];

        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < NDB; i++) begin
            // Any cycle agreeing with the stable level restarts the count.
            if (s[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = s[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end

        // Pulse lands on the same edge the stable level first reads 1.
        press_d = ~stable_q[2:0] & stable_d[2:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            press_q  <= '0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign A          = stable_q[0];
    assign B          = stable_q[1];
    assign calc       = stable_q[2];
    assign a_press    = press_q[0];
    assign b_press    = press_q[1];
    assign calc_press = press_q[2];
`ifdef IO_SWITCH_DEBOUNCE_EN
    assign switch = stable_q[NDB-1:3];
`else
    assign switch = s[N-1:3];
`endif
endmodule

// File: tb/tb_io_input_cond.sv
// tb/tb_io_input_cond.sv - directed bench for io_input_cond (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
module tb_io_input_cond;
    logic        clk = 1'b0;
    logic        rst;
    logic        btn_a_raw, btn_b_raw, btn_calc_raw;
    logic [15:0] switch_raw;
    logic        A, B, calc;
    logic [15:0] switch;
    logic        a_press, b_press, calc_press;
    int          errors = 0;
    int          checks = 0;

`ifdef IO_SWITCH_DEBOUNCE_EN
    localparam int SW_LAT = 6;
`else
    localparam int SW_LAT = 2;
`endif

    io_input_cond #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .SW_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .btn_a_raw(btn_a_raw), .btn_b_raw(btn_b_raw), .btn_calc_raw(btn_calc_raw),
        .switch_raw(switch_raw),
        .A(A), .B(B), .calc(calc), .switch(switch),
        .a_press(a_press), .b_press(b_press), .calc_press(calc_press)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; btn_a_raw = 1'b1; btn_b_raw = 1'b1; btn_calc_raw = 1'b1;
        switch_raw = 16'hFFFF;
        tick(2);
        checks++;
        if ({A, B, calc, switch, a_press, b_press, calc_press} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {A, B, calc, switch, a_press, b_press, calc_press});
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            checks++;
            if ({A, B, calc} !== {3{k >= 6}} ||
                {a_press, b_press, calc_press} !== {3{k == 6}}) begin
                errors++;
                $display("FAIL reset_release edge=%0d got lvl=%b press=%b want lvl=%b press=%b",
                         k, {A, B, calc}, {a_press, b_press, calc_press},
                         {3{k >= 6}}, {3{k == 6}});
            end
        end
        btn_a_raw = 1'b0; btn_b_raw = 1'b0; btn_calc_raw = 1'b0; switch_raw = 16'h0000;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            checks++;
            if ({A, B, calc} !== {3{k < 6}} || {a_press, b_press, calc_press} !== 3'b000) begin
                errors++;
                $display("FAIL release_no_pulse edge=%0d got lvl=%b press=%b want lvl=%b press=000",
                         k, {A, B, calc}, {a_press, b_press, calc_press}, {3{k < 6}});
            end
        end
    endtask

    task automatic test_press_a;
        btn_a_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            checks++;
            if (A !== (k >= 6) || a_press !== (k == 6) ||
                {B, calc, b_press, calc_press} !== 4'b0000) begin
                errors++;
                $display("FAIL press_a edge=%0d got A=%b a_press=%b others=%b want A=%b a_press=%b others=0000",
                         k, A, a_press, {B, calc, b_press, calc_press}, k >= 6, k == 6);
            end
        end
        btn_a_raw = 1'b0;
        tick(8);
    endtask

    task automatic test_glitch_b;
        btn_b_raw = 1'b1;
        tick(3);
        btn_b_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            checks++;
            if ({B, b_press} !== 2'b00) begin
                errors++;
                $display("FAIL glitch_b edge=%0d got B=%b b_press=%b want 0 0", k, B, b_press);
            end
        end
        btn_b_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            checks++;
            if (B !== (k >= 6) || b_press !== (k == 6)) begin
                errors++;
                $display("FAIL hold_b edge=%0d got B=%b b_press=%b want B=%b b_press=%b",
                         k, B, b_press, k >= 6, k == 6);
            end
        end
        btn_b_raw = 1'b0;
        tick(8);
    endtask

    task automatic test_bounce_calc;
        logic [8:0] pat = 9'b1_1110_1101; // bit 0 applied first: 1,0,1,1,0,1,1,1,1
        int presses = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k <= 9) btn_calc_raw = pat[k-1];
            tick(1);
            if (calc_press === 1'b1) presses++;
            checks++;
            if (calc !== (k >= 11)) begin
                errors++;
                $display("FAIL bounce_calc edge=%0d got calc=%b want %b", k, calc, k >= 11);
            end
        end
        checks++;
        if (presses !== 1) begin
            errors++;
            $display("FAIL bounce_calc_presses got=%0d want=1", presses);
        end
        btn_calc_raw = 1'b0;
        tick(8);
    endtask

    task automatic test_switch;
        logic [15:0] exp;
        switch_raw = 16'hA5C3;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp = (k >= SW_LAT) ? 16'hA5C3 : 16'h0000;
            checks++;
            if (switch !== exp) begin
                errors++;
                $display("FAIL switch_step edge=%0d got=%h want=%h", k, switch, exp);
            end
        end
        switch_raw = 16'hA5C2;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) switch_raw = 16'hA5C3;
`ifdef IO_SWITCH_DEBOUNCE_EN
            exp = 16'hA5C3;
`else
            exp = (k == 2 || k == 3) ? 16'hA5C2 : 16'hA5C3;
`endif
            tick(1);
            checks++;
            if (switch !== exp) begin
                errors++;
                $display("FAIL switch_glitch edge=%0d got=%h want=%h", k, switch, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        btn_a_raw = 1'b1;
        tick(8);
        checks++;
        if (A !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got A=%b want 1", A);
        end
        btn_a_raw = 1'b0;
        tick(3);
        btn_a_raw = 1'b1;
        rst = 1'b1;
        tick(1);
        checks++;
        if ({A, a_press, switch} !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset got A=%b a_press=%b switch=%h want 0 0 0000", A, a_press, switch);
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            checks++;
            if (A !== (k >= 6) || a_press !== (k == 6)) begin
                errors++;
                $display("FAIL mid_reassert edge=%0d got A=%b a_press=%b want A=%b a_press=%b",
                         k, A, a_press, k >= 6, k == 6);
            end
        end
    endtask

    initial begin
        test_reset;
        test_press_a;
        test_glitch_b;
        test_bounce_calc;
        test_switch;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
